rom_load_ctrl: RTL and testbench
================================

// Module: rom_load_ctrl
// PURPOSE
//   Program-load controller for the instruction ROM (dual_ram-backed, word-addressed via byte addr [13:2]).
//   Accepts a length-prefixed little-endian byte stream (e.g. from a UART/debug RX), packs bytes into
//   32-bit words and drives the ROM write port with sequential word addresses from 0.
//   Arbitrates the ROM read port: core fetch is gated off and the core held while a load is in progress.
// PARAMETERS
//   AW        12   ROM word-address width; capacity = 2**AW words
// PORTS
//   clk            in   1    single clock
//   rst            in   1    synchronous reset, active-high
//   load_start_i   in   1    pulse: begin a load session (honoured only in IDLE)
//   byte_valid_i   in   1    stream byte valid
//   byte_data_i    in   8    stream byte
//   byte_ready_o   out  1    controller can accept a byte this cycle
//   core_r_en_i    in   1    core fetch read enable
//   core_r_addr_i  in   32   core fetch byte address
//   rom_r_en_o     out  1    to ROM r_en
//   rom_r_addr_o   out  32   to ROM r_addr_i
//   rom_w_en_o     out  1    to ROM w_en (one-cycle pulse per word)
//   rom_w_addr_o   out  32   to ROM w_addr_i (byte address = word_idx<<2)
//   rom_w_data_o   out  32   to ROM w_data_i
//   core_hold_o    out  1    hold core in reset/stall while loading
//   load_done_o    out  1    one-cycle pulse at end of session (success or error)
//   load_err_o     out  1    sticky: length exceeded capacity; cleared by next accepted load_start_i
//   words_wr_o     out  AW+1 words written in current/last session
// BEHAVIOUR
//   - Reset: state=IDLE; all outputs 0 (rom_w_*=0, byte_ready_o=0, hold=0, done=0, err=0, words_wr_o=0);
//     byte/word counters cleared. rst mid-session aborts immediately, no further writes, no done pulse.
//   - FSM IDLE -> LEN -> DATA -> DONE -> IDLE.
//     IDLE: byte_ready_o=0. load_start_i=1 -> LEN; clears err, words_wr_o, byte_cnt, word_idx.
//     LEN : byte_ready_o=1. Accept = valid&ready. Byte k (0..3) -> len[8k+7:8k]. On 4th accept:
//           len==0 -> DONE; len > 2**AW -> err=1, DONE (nothing written); else -> DATA.
//     DATA: byte_ready_o=1. Byte k -> word[8k+7:8k]. On 4th accept, next cycle (registered):
//           rom_w_en_o=1, rom_w_addr_o={word_idx,2'b00} zero-extended, rom_w_data_o=assembled word;
//           word_idx++, words_wr_o++. If word_idx+1==len -> DONE else stay DATA.
//     DONE: one cycle; load_done_o=1; byte_ready_o=0; final word write (if any) lands this cycle. -> IDLE.
//   - Write latency: 1 cycle from 4th byte accept to rom_w_en_o. Max throughput one byte/cycle;
//     back-to-back valid gives one write every 4 cycles. Gaps in byte_valid_i stall assembly, no timeout.
//   - load_start_i ignored in LEN/DATA/DONE. Byte valid outside LEN/DATA ignored (ready=0).
//   - len==2**AW accepted: last address = (2**AW-1)<<2; word_idx never wraps.
//   - core_hold_o = 1 in LEN, DATA, DONE (registered with state, first high the cycle after start).
//   - Read arbitration (combinational): rom_r_en_o = core_r_en_i & ~core_hold_o;
//     rom_r_addr_o = core_r_addr_i. Read and write ports never both active from this block.
//   - All counters natural width; byte_cnt 2 bits wraps 3->0 on word completion.
// STRUCTURE
//   - Shared package/header: state encodings (ST_IDLE/ST_LEN/ST_DATA/ST_DONE), ROM_AW=12 default.
//   - One natural sub-module: byte_packer (2-bit counter + 32-bit LE shift/assemble, word_valid pulse),
//     reused for both length and data words. FSM, address counter, arbitration in top.
//   - Top instantiates alongside rom; rom ports wired directly to rom_* outputs.
// TESTING
//   1. Reset values: assert rst 3 cycles -> all outputs 0, state IDLE; core_r_en_i=1 passes to rom_r_en_o.
//   2. Basic load: start, bytes 02 00 00 00, 78 56 34 12, EF BE AD DE -> writes 0x12345678@0x0,
//      0xDEADBEEF@0x4; done pulse once; words_wr_o=2; hold low next cycle.
//   3. Zero length: start, 00 00 00 00 -> DONE next cycle, no rom_w_en_o, err=0, done pulse.
//   4. Overflow (AW=12): len 0x00001001 -> err=1, done pulse, no writes; next start clears err.
//   5. Gated fetch / stalls: during load core_r_en_i=1 -> rom_r_en_o=0; random valid gaps -> same data/addrs
//      as scenario 2; load_start_i mid-DATA ignored.
//   6. Reset mid-load: rst after 5 of 8 data bytes -> 1 write only, no done, IDLE, hold=0, outputs 0.

Source files
------------

// File: rtl/rom_load_ctrl_pkg.sv
// Shared definitions for the instruction-ROM program-load controller:
// FSM state encodings and the default ROM word-address width.
package rom_load_ctrl_pkg;

   localparam int ROM_AW = 12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LEN  = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/rom_load_ctrl_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clr             synchronous clear of the byte counter and partial word
//   byte_en         a byte is accepted this cycle
//   byte_data[7:0]  accepted byte
//   word_valid      high in the cycle the 4th byte of a word is accepted
//   word[31:0]      assembled word, valid together with word_valid
module rom_load_ctrl_byte_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        byte_en,
   input  logic [7:0]  byte_data,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0]  byte_cnt;
   logic [23:0] low_bytes;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         byte_cnt  <= 2'd0;
         low_bytes <= 24'd0;
      end else if (byte_en) begin
         byte_cnt  <= byte_cnt + 2'd1;
         // Shift right so the first byte ends up in the least significant lane.
         low_bytes <= {byte_data, low_bytes[23:8]};
      end
   end

   // The 4th byte is used directly so the word is available in its accept cycle.
   assign word_valid = byte_en && (byte_cnt == 2'd3);
   assign word       = {byte_data, low_bytes};

endmodule

// File: rtl/rom_load_ctrl.sv
// Program-load controller for the instruction ROM. Receives a length-prefixed
// little-endian byte stream, writes packed words to the ROM from address 0,
// and gates core fetches off the ROM read port while a load is in progress.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   load_start_i                  begin a load session (IDLE only)
//   byte_valid_i/byte_data_i      stream input, byte_ready_o handshake
//   core_r_en_i/core_r_addr_i     core fetch request
//   rom_r_en_o/rom_r_addr_o       ROM read port
//   rom_w_en_o/_addr_o/_data_o    ROM write port
//   core_hold_o                   core held while loading
//   load_done_o                   one-cycle end-of-session pulse
//   load_err_o                    sticky length-overflow flag
//   words_wr_o                    words written this/last session
//
// state   | meaning
// IDLE    | waiting for load_start_i, ROM read port owned by the core
// LEN     | collecting the 4-byte little-endian word count
// DATA    | collecting data words, one ROM write per completed word
// DONE    | one-cycle end of session, final write lands here
module rom_load_ctrl
   import rom_load_ctrl_pkg::*;
#(
   parameter int AW = ROM_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_start_i,
   input  logic          byte_valid_i,
   input  logic [7:0]    byte_data_i,
   output logic          byte_ready_o,
   input  logic          core_r_en_i,
   input  logic [31:0]   core_r_addr_i,
   output logic          rom_r_en_o,
   output logic [31:0]   rom_r_addr_o,
   output logic          rom_w_en_o,
   output logic [31:0]   rom_w_addr_o,
   output logic [31:0]   rom_w_data_o,
   output logic          core_hold_o,
   output logic          load_done_o,
   output logic          load_err_o,
   output logic [AW:0]   words_wr_o
);

   localparam logic [31:0] CAPACITY = 32'd1 << AW;

   state_t        state;
   state_t        state_nxt;
   logic [31:0]   len;
   logic [AW:0]   word_idx;
   logic          accept;
   logic          pk_valid;
   logic [31:0]   pk_word;
   logic [31:0]   idx_next;

   assign byte_ready_o = (state == ST_LEN) || (state == ST_DATA);
   assign accept       = byte_valid_i && byte_ready_o;
   assign idx_next     = 32'(word_idx) + 32'd1;

   rom_load_ctrl_byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clr        (state == ST_IDLE),
      .byte_en    (accept),
      .byte_data  (byte_data_i),
      .word_valid (pk_valid),
      .word       (pk_word)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (load_start_i) state_nxt = ST_LEN;
         ST_LEN: begin
            if (pk_valid) begin
               if ((pk_word == 32'd0) || (pk_word > CAPACITY)) state_nxt = ST_DONE;
               else                                            state_nxt = ST_DATA;
            end
         end
         ST_DATA: if (pk_valid && (idx_next == len)) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         len          <= 32'd0;
         word_idx     <= '0;
         load_err_o   <= 1'b0;
         rom_w_en_o   <= 1'b0;
         rom_w_addr_o <= 32'd0;
         rom_w_data_o <= 32'd0;
      end else begin
         rom_w_en_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (load_start_i) begin
                  load_err_o <= 1'b0;
                  word_idx   <= '0;
               end
            end
            ST_LEN: begin
               if (pk_valid) begin
                  len <= pk_word;
                  if (pk_word > CAPACITY) load_err_o <= 1'b1;
               end
            end
            ST_DATA: begin
               if (pk_valid) begin
                  rom_w_en_o   <= 1'b1;
                  // word_idx stays below 2**AW while writing, so its MSB is never needed here.
                  rom_w_addr_o <= {{(30-AW){1'b0}}, word_idx[AW-1:0], 2'b00};
                  rom_w_data_o <= pk_word;
                  word_idx     <= word_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign words_wr_o   = word_idx;
   assign core_hold_o  = (state != ST_IDLE);
   assign load_done_o  = (state == ST_DONE);
   assign rom_r_en_o   = core_r_en_i && !core_hold_o;
   assign rom_r_addr_o = core_r_addr_i;

endmodule

// File: tb/tb_rom_load_ctrl.sv
module tb_rom_load_ctrl;
   import rom_load_ctrl_pkg::*;

   localparam int AW = ROM_AW;

   logic          clk;
   logic          rst;
   logic          load_start_i;
   logic          byte_valid_i;
   logic [7:0]    byte_data_i;
   logic          byte_ready_o;
   logic          core_r_en_i;
   logic [31:0]   core_r_addr_i;
   logic          rom_r_en_o;
   logic [31:0]   rom_r_addr_o;
   logic          rom_w_en_o;
   logic [31:0]   rom_w_addr_o;
   logic [31:0]   rom_w_data_o;
   logic          core_hold_o;
   logic          load_done_o;
   logic          load_err_o;
   logic [AW:0]   words_wr_o;

   rom_load_ctrl #(.AW(AW)) dut (
      .clk           (clk),
      .rst           (rst),
      .load_start_i  (load_start_i),
      .byte_valid_i  (byte_valid_i),
      .byte_data_i   (byte_data_i),
      .byte_ready_o  (byte_ready_o),
      .core_r_en_i   (core_r_en_i),
      .core_r_addr_i (core_r_addr_i),
      .rom_r_en_o    (rom_r_en_o),
      .rom_r_addr_o  (rom_r_addr_o),
      .rom_w_en_o    (rom_w_en_o),
      .rom_w_addr_o  (rom_w_addr_o),
      .rom_w_data_o  (rom_w_data_o),
      .core_hold_o   (core_hold_o),
      .load_done_o   (load_done_o),
      .load_err_o    (load_err_o),
      .words_wr_o    (words_wr_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic        err;
      logic [AW:0] words;
   } done_t;

   wr_t   wr_q[$];
   done_t done_q[$];
   wr_t   mon_wr;
   done_t mon_done;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops expected writes / session ends whenever the DUT presents one.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (rom_w_en_o === 1'b1) begin
            if (wr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                        rom_w_addr_o, rom_w_data_o);
            end else begin
               mon_wr = wr_q.pop_front();
               chk("wr_addr", 64'(rom_w_addr_o), 64'(mon_wr.addr));
               chk("wr_data", 64'(rom_w_data_o), 64'(mon_wr.data));
            end
         end
         if (load_done_o === 1'b1) begin
            if (done_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected done=0");
            end else begin
               mon_done = done_q.pop_front();
               chk("done_err", 64'(load_err_o), 64'(mon_done.err));
               chk("done_words", 64'(words_wr_o), 64'(mon_done.words));
               chk("done_hold", 64'(core_hold_o), 64'd1);
               chk("done_ready", 64'(byte_ready_o), 64'd0);
            end
         end
      end
   end

   // All tasks below start and end at a negedge.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      byte_valid_i = 1'b1;
      byte_data_i  = b;
      while (byte_ready_o !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("byte_accept_timeout", 64'd0, 64'd1);
      @(negedge clk);
      byte_valid_i = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int k = 0; k < 4; k++) begin
         repeat (gap) @(negedge clk);
         send_byte(w[8*k +: 8]);
      end
   endtask

   task automatic start_load();
      load_start_i = 1'b1;
      @(negedge clk);
      load_start_i = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (load_done_o !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("done_timeout", 64'd0, 64'd1);
      @(negedge clk);
      chk("hold_after_done", 64'(core_hold_o), 64'd0);
      chk("ready_after_done", 64'(byte_ready_o), 64'd0);
   endtask

   task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      wr_q.push_back(e);
   endtask

   task automatic push_done(input logic e, input int w);
      done_t d;
      d.err   = e;
      d.words = (AW+1)'(w);
      done_q.push_back(d);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;

      rst           = 1'b1;
      load_start_i  = 1'b0;
      byte_valid_i  = 1'b0;
      byte_data_i   = 8'h00;
      core_r_en_i   = 1'b1;
      core_r_addr_i = 32'h0000_0100;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_w_en", 64'(rom_w_en_o), 64'd0);
      chk("rst_w_addr", 64'(rom_w_addr_o), 64'd0);
      chk("rst_w_data", 64'(rom_w_data_o), 64'd0);
      chk("rst_ready", 64'(byte_ready_o), 64'd0);
      chk("rst_hold", 64'(core_hold_o), 64'd0);
      chk("rst_done", 64'(load_done_o), 64'd0);
      chk("rst_err", 64'(load_err_o), 64'd0);
      chk("rst_words", 64'(words_wr_o), 64'd0);
      chk("rst_r_en", 64'(rom_r_en_o), 64'd1);
      chk("rst_r_addr", 64'(rom_r_addr_o), 64'h100);
      rst = 1'b0;
      @(negedge clk);

      // Bytes offered in IDLE are not taken
      byte_valid_i = 1'b1;
      byte_data_i  = 8'h55;
      @(negedge clk);
      chk("idle_ready", 64'(byte_ready_o), 64'd0);
      @(negedge clk);
      byte_valid_i = 1'b0;

      // Basic two-word load
      start_load();
      chk("load_hold", 64'(core_hold_o), 64'd1);
      chk("load_r_en_gated", 64'(rom_r_en_o), 64'd0);
      push_done(1'b0, 2);
      push_wr(32'h0, 32'h1234_5678);
      push_wr(32'h4, 32'hDEAD_BEEF);
      send_word(32'd2, 0);
      send_word(32'h1234_5678, 0);
      send_word(32'hDEAD_BEEF, 0);
      wait_done();
      chk("basic_words_idle", 64'(words_wr_o), 64'd2);
      chk("idle_r_en", 64'(rom_r_en_o), 64'd1);

      // Zero length
      push_done(1'b0, 0);
      start_load();
      send_word(32'd0, 0);
      wait_done();
      chk("zero_err", 64'(load_err_o), 64'd0);

      // Overflow: one word beyond capacity
      push_done(1'b1, 0);
      start_load();
      send_word(32'h0000_1001, 0);
      wait_done();
      chk("ovf_err_sticky", 64'(load_err_o), 64'd1);

      // Next start clears err; stalled stream and ignored mid-DATA start
      start_load();
      chk("err_cleared", 64'(load_err_o), 64'd0);
      chk("words_cleared", 64'(words_wr_o), 64'd0);
      push_done(1'b0, 2);
      push_wr(32'h0, 32'h1234_5678);
      push_wr(32'h4, 32'hDEAD_BEEF);
      send_word(32'd2, 1);
      send_word(32'h1234_5678, 2);
      send_byte(8'hEF);
      send_byte(8'hBE);
      start_load();
      chk("stall_r_en_gated", 64'(rom_r_en_o), 64'd0);
      repeat (3) @(negedge clk);
      send_byte(8'hAD);
      repeat (2) @(negedge clk);
      send_byte(8'hDE);
      wait_done();

      // Full capacity: last address (2**AW-1)<<2, no wrap
      push_done(1'b0, 1 << AW);
      start_load();
      send_word(32'd1 << AW, 0);
      for (int i = 0; i < (1 << AW); i++) begin
         d = (32'(i) << 16) | (~32'(i) & 32'h0000_FFFF);
         push_wr(32'(i) << 2, d);
         send_word(d, 0);
      end
      wait_done();
      chk("full_words", 64'(words_wr_o), 64'd4096);
      chk("full_err", 64'(load_err_o), 64'd0);

      // Reset after 5 of 8 data bytes
      start_load();
      send_word(32'd2, 0);
      push_wr(32'h0, 32'h1122_3344);
      send_word(32'h1122_3344, 0);
      send_byte(8'h99);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_w_en", 64'(rom_w_en_o), 64'd0);
      chk("mid_rst_hold", 64'(core_hold_o), 64'd0);
      chk("mid_rst_ready", 64'(byte_ready_o), 64'd0);
      chk("mid_rst_done", 64'(load_done_o), 64'd0);
      chk("mid_rst_words", 64'(words_wr_o), 64'd0);
      chk("mid_rst_w_addr", 64'(rom_w_addr_o), 64'd0);
      chk("mid_rst_w_data", 64'(rom_w_data_o), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("post_rst_hold", 64'(core_hold_o), 64'd0);
      chk("post_rst_r_en", 64'(rom_r_en_o), 64'd1);

      chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
      chk("done_q_empty", 64'(done_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
